// File: rtl/serial_parity_checker_if.sv
// Word-level side of the serial parity receiver: serial line in, recovered word and status out.
interface serial_parity_checker_if #(
    parameter int DATA_W = 8
);
    logic              x;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              par_err;
    logic              frm_err;
    logic              busy;

    modport master (
        output x,
        input  data,
        input  valid,
        input  par_err,
        input  frm_err,
        input  busy
    );

    modport slave (
        input  x,
        output data,
        output valid,
        output par_err,
        output frm_err,
        output busy
    );
endinterface

// File: rtl/serial_parity_checker.sv
// Serial parity link receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Reports each completed frame with a one-cycle valid and parity/framing error flags.
module serial_parity_checker #(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_parity_checker_if.slave bus
);
    localparam int              CW   = $clog2(DATA_W);
    localparam logic [CW-1:0]   LAST = CW'(DATA_W - 1);
    localparam logic            ODD  = (ODD_PARITY != 0);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              rpar, rpar_n;
    logic              err, err_n;
    logic [DATA_W-1:0] data_r, data_n;
    logic              valid_r, valid_n;
    logic              perr_r, perr_n;
    logic              ferr_r, ferr_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            rpar    <= 1'b0;
            err     <= 1'b0;
            data_r  <= '0;
            valid_r <= 1'b0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shreg   <= shreg_n;
            rpar    <= rpar_n;
            err     <= err_n;
            data_r  <= data_n;
            valid_r <= valid_n;
            perr_r  <= perr_n;
            ferr_r  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        rpar_n  = rpar;
        err_n   = err;
        data_n  = data_r;
        valid_n = 1'b0;
        perr_n  = perr_r;
        ferr_n  = ferr_r;

        case (state)
            IDLE: begin
                if (bus.x) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    rpar_n  = 1'b0;
                end
            end
            DATA: begin
                shreg_n[cnt] = bus.x;
                rpar_n       = rpar ^ bus.x;
                if (cnt == LAST) begin
                    state_n = PARITY;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PARITY: begin
                err_n   = rpar ^ bus.x ^ ODD;
                state_n = STOP;
            end
            STOP: begin
                data_n  = shreg;
                perr_n  = err;
                ferr_n  = bus.x;
                valid_n = 1'b1;
                // A high stop bit is a line fault; wait for it to drop before hunting for a start bit.
                state_n = bus.x ? WAIT_IDLE : IDLE;
            end
            WAIT_IDLE: begin
                if (!bus.x) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.data    = data_r;
    assign bus.valid   = valid_r;
    assign bus.par_err = perr_r;
    assign bus.frm_err = ferr_r;
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: one even-parity and one odd-parity instance.
module tb_serial_parity_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   sel = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_parity_checker_if #(.DATA_W(8)) ife ();
    serial_parity_checker_if #(.DATA_W(8)) ifo ();

    serial_parity_checker #(.DATA_W(8), .ODD_PARITY(0)) dut_e (.clk(clk), .rst(rst), .bus(ife));
    serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1)) dut_o (.clk(clk), .rst(rst), .bus(ifo));

    logic [7:0] cur_data;
    logic       cur_valid, cur_perr, cur_ferr, cur_busy;
    assign cur_data  = sel ? ifo.data    : ife.data;
    assign cur_valid = sel ? ifo.valid   : ife.valid;
    assign cur_perr  = sel ? ifo.par_err : ife.par_err;
    assign cur_ferr  = sel ? ifo.frm_err : ife.frm_err;
    assign cur_busy  = sel ? ifo.busy    : ife.busy;

    typedef struct {
        bit         odd;
        logic [7:0] d;
        logic       p;
        logic       s;
        logic [7:0] ed;
        logic       ep;
        logic       ef;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive x on the selected instance, then sample 1 time unit after the next rising edge.
    task automatic tick(input logic xv);
        ife.x = (sel == 1'b0) ? xv : 1'b0;
        ifo.x = (sel == 1'b1) ? xv : 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit s_, input logic [7:0] d, input logic p, input logic st,
                        output int early);
        early = 0;
        sel   = s_;
        tick(1'b1);
        if (cur_valid) early++;
        for (int i = 0; i < 8; i++) begin
            tick(d[i]);
            if (cur_valid) early++;
        end
        tick(p);
        if (cur_valid) early++;
        tick(st);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int early;
        int c1, c2, nv;

        vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

        ife.x = 1'b0;
        ifo.x = 1'b0;
        rst   = 1'b1;
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sel = bit'(k);
            chk("rst_data", cur_data, 8'h00);
            chk("rst_valid", cur_valid, 1'b0);
            chk("rst_par_err", cur_perr, 1'b0);
            chk("rst_frm_err", cur_ferr, 1'b0);
            chk("rst_busy", cur_busy, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].odd, vecs[i].d, vecs[i].p, vecs[i].s, early);
            chk("vec_no_early_valid", early, 0);
            chk("vec_valid", cur_valid, 1'b1);
            chk("vec_data", cur_data, vecs[i].ed);
            chk("vec_par_err", cur_perr, vecs[i].ep);
            chk("vec_frm_err", cur_ferr, vecs[i].ef);
            tick(1'b0);
            chk("vec_valid_pulse_end", cur_valid, 1'b0);
            chk("vec_data_hold", cur_data, vecs[i].ed);
            tick(1'b0);
        end

        // Framing error with the line stuck high afterwards.
        send(1'b0, 8'h0F, 1'b0, 1'b1, early);
        chk("frm_no_early_valid", early, 0);
        chk("frm_valid", cur_valid, 1'b1);
        chk("frm_data", cur_data, 8'h0F);
        chk("frm_par_err", cur_perr, 1'b0);
        chk("frm_frm_err", cur_ferr, 1'b1);
        chk("frm_busy_wait", cur_busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            chk("frm_busy_hold", cur_busy, 1'b1);
            chk("frm_valid_low", cur_valid, 1'b0);
        end
        tick(1'b0);
        chk("frm_busy_release", cur_busy, 1'b0);
        nv = 0;
        for (int i = 0; i < 14; i++) begin
            tick(1'b0);
            if (cur_valid) nv++;
        end
        chk("frm_no_spurious_frame", nv, 0);
        chk("frm_flags_hold", {cur_perr, cur_ferr}, 2'b01);

        // Back-to-back frames: next start bit immediately after the stop bit.
        send(1'b0, 8'h3C, 1'b0, 1'b0, early);
        c1 = cyc;
        chk("b2b1_valid", cur_valid, 1'b1);
        chk("b2b1_data", cur_data, 8'h3C);
        chk("b2b1_errs", {cur_perr, cur_ferr}, 2'b00);
        send(1'b0, 8'hC3, 1'b0, 1'b0, early);
        c2 = cyc;
        chk("b2b2_no_early_valid", early, 0);
        chk("b2b2_valid", cur_valid, 1'b1);
        chk("b2b2_data", cur_data, 8'hC3);
        chk("b2b2_errs", {cur_perr, cur_ferr}, 2'b00);
        chk("b2b_spacing", c2 - c1, 11);
        tick(1'b0);
        tick(1'b0);

        // Reset after the 4th data bit of a 0x55 frame.
        sel = 1'b0;
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        chk("mid_busy_before", cur_busy, 1'b1);
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        chk("mid_busy", cur_busy, 1'b0);
        chk("mid_valid", cur_valid, 1'b0);
        chk("mid_data", cur_data, 8'h00);
        chk("mid_errs", {cur_perr, cur_ferr}, 2'b00);
        nv = 0;
        for (int i = 0; i < 13; i++) begin
            tick(1'b0);
            if (cur_valid) nv++;
        end
        chk("mid_no_valid", nv, 0);
        send(1'b0, 8'h55, 1'b0, 1'b0, early);
        chk("post_rst_no_early_valid", early, 0);
        chk("post_rst_valid", cur_valid, 1'b1);
        chk("post_rst_data", cur_data, 8'h55);
        chk("post_rst_errs", {cur_perr, cur_ferr}, 2'b00);
        tick(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
